instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the RISC-V single-cycle/pipelined core. Owns the program counter, drives the word address into the program memory ROM (combinational read), and captures the returned instruction into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, out-of-range and misaligned fetch faults with a halt state, and counts retired fetches.

## Interface
- DATA_WIDTH, 32, width of PC, address and instruction
- MEMORY_DEPTH, 32, number of instruction words in program memory
- RESET_PC, 32'h0040_0000, text-segment base; PC value after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace IF/ID contents with a bubble
- redirect_valid  in  1  load redirect_target into PC (taken branch/jump)
- redirect_target  in  DATA_WIDTH  new PC
- imem_instruction  in  DATA_WIDTH  word returned by program memory for imem_address
- imem_address  out  DATA_WIDTH  byte address to program memory; equals pc_q
- if_id_instruction  out  DATA_WIDTH  registered instruction
- if_id_pc  out  DATA_WIDTH  PC of registered instruction
- if_id_pc_plus4  out  DATA_WIDTH  if_id_pc + 4
- if_id_valid  out  1  IF/ID holds a real instruction or a fault marker
- if_id_fault  out  1  registered entry is a fetch fault
- halted  out  1  stage in HALT state
- fetch_count  out  32  number of valid (non-fault) instructions captured

## Operation
- States: RUN, HALT. Reset -> RUN.
- Fault condition (RUN, evaluated on pc_q): pc_q[1:0] != 0, or pc_q < RESET_PC, or pc_q - RESET_PC >= 4*MEMORY_DEPTH (unsigned, DATA_WIDTH bits).
- Per rising edge, PC next-value priority: redirect_valid -> redirect_target; else stall -> hold; else HALT -> hold; else RUN with fault -> hold; else pc_q + 4 (wraps modulo 2^DATA_WIDTH).
- IF/ID update priority: redirect_valid or flush -> bubble; else stall -> hold; else HALT -> bubble; else RUN with fault -> capture {instruction=NOP_INSTR, pc=pc_q, pc_plus4=pc_q+4, valid=1, fault=1}; else capture {imem_instruction, pc_q, pc_q+4, valid=1, fault=0}.
- Bubble = {NOP_INSTR, pc 0, pc_plus4 0, valid 0, fault 0}.
- State transitions: RUN -> HALT when fault entry is captured (no redirect, no flush, no stall). HALT -> RUN on redirect_valid. redirect_valid in RUN keeps RUN.
- fetch_count increments by 1 (wraps at 2^32) on every edge that captures a non-fault instruction; holds otherwise.
- Redirect to a faulting target is accepted; the fault is detected in the following cycle.

## Timing
- Reset values: pc_q = RESET_PC, imem_address = RESET_PC, if_id_instruction = NOP_INSTR, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_valid = 0, if_id_fault = 0, halted = 0, fetch_count = 0.
- imem_address is combinational from pc_q; imem_instruction must settle within the same cycle (ROM is asynchronous read).
- Latency: instruction at pc_q appears on if_id_* one edge later.
- Redirect: target drives imem_address the cycle after redirect_valid; first target instruction valid on IF/ID two edges after redirect_valid; exactly one bubble inserted.
- halted is registered state, asserted from the edge that captures the fault entry.
- Reset asserted mid-operation clears all state immediately (no clock needed); first fetch at RESET_PC after deassertion.

## Test plan
- Reset release, memory words 0..3 = 0x00500093, 0x00a00113, 0x002081b3, 0x00000013 -> IF/ID shows them on edges 1..4 with pc 0x00400000..0x0040000C, valid=1, fetch_count=4.
- stall high 2 cycles while IF/ID holds pc 0x00400004 -> IF/ID and imem_address unchanged for 2 cycles, fetch_count unchanged, then resumes at 0x00400008.
- redirect_valid with target 0x00400010 and stall same cycle -> next edge pc_q=0x00400010, IF/ID bubble (valid 0, NOP_INSTR), following edge IF/ID pc=0x00400010.
- Sequential fetch past last word (pc 0x00400080, DEPTH 32) -> IF/ID fault entry pc=0x00400080 valid=1 fault=1, halted=1, pc_q holds, subsequent IF/ID bubbles; redirect to 0x00400000 -> halted=0, fetch resumes.
- redirect to 0x00400006 -> fault entry with pc 0x00400006, halted=1.
- reset asserted asynchronously mid-run with fetch_count=7 -> all outputs return to reset values before next edge.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage
// Function : Owns the PC, addresses an async-read ROM and fills the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    output logic [DATA_WIDTH-1:0] imem_address,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  if_id_fault,
    output logic                  halted,
    output logic [31:0]           fetch_count
);

    localparam logic [DATA_WIDTH-1:0] c_ROM_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_FOUR      = DATA_WIDTH'(4);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   ifpc_q, ifpc_d;
    logic [DATA_WIDTH-1:0]   ifpc4_q, ifpc4_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;
    logic [31:0]             count_q, count_d;

    logic [DATA_WIDTH-1:0]   w_offset;
    logic [DATA_WIDTH-1:0]   w_pc_plus4;
    logic                    w_fault;

    // Subtraction wraps for pc_q < RESET_PC, so that case is tested separately.
    assign w_offset   = pc_q - RESET_PC;
    assign w_pc_plus4 = pc_q + c_FOUR;
    assign w_fault    = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (w_offset >= c_ROM_BYTES);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;

        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (stall || (state_q == S_HALT) || w_fault) begin
            pc_d = pc_q;
        end else begin
            pc_d = w_pc_plus4;
        end

        if (redirect_valid || flush || (!stall && (state_q == S_HALT))) begin
            instr_d = NOP_INSTR;
            ifpc_d  = '0;
            ifpc4_d = '0;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!stall) begin
            instr_d = w_fault ? NOP_INSTR : imem_instruction;
            ifpc_d  = pc_q;
            ifpc4_d = w_pc_plus4;
            valid_d = 1'b1;
            fault_d = w_fault;
            if (w_fault) begin
                state_d = S_HALT;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (redirect_valid) begin
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign imem_address      = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc          = ifpc_q;
    assign if_id_pc_plus4    = ifpc4_q;
    assign if_id_valid       = valid_q;
    assign if_id_fault       = fault_q;
    assign halted            = (state_q == S_HALT);
    assign fetch_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_stage
// Function : Directed self-checking bench for instruction_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

    localparam logic [31:0] c_BASE = 32'h0040_0000;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_instruction;
    logic [31:0] imem_address;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        if_id_fault;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [0:31];
    logic [31:0] w_off;
    int          tests_run = 0;
    int          tests_failed = 0;

    instruction_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_instruction  (imem_instruction),
        .imem_address      (imem_address),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .if_id_fault       (if_id_fault),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    // Asynchronous ROM; out-of-range reads return a recognisable junk word.
    always_comb begin
        w_off = imem_address - c_BASE;
        imem_instruction = 32'hDEAD_BEEF;
        if (imem_address >= c_BASE && w_off < 32'd128)
            imem_instruction = rom[w_off[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic valid, input logic fault);
        check({tag, ".instr"}, if_id_instruction, instr);
        check({tag, ".pc"},    if_id_pc, pc);
        check({tag, ".pc4"},   if_id_pc_plus4, (valid ? pc + 32'd4 : 32'd0));
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check({tag, ".fault"}, {31'd0, if_id_fault}, {31'd0, fault});
    endtask

    task automatic check_reset_state(input string tag);
        check_ifid(tag, c_NOP, 32'd0, 1'b0, 1'b0);
        check({tag, ".addr"},   imem_address, c_BASE);
        check({tag, ".halted"}, {31'd0, halted}, 32'd0);
        check({tag, ".count"},  fetch_count, 32'd0);
    endtask

    initial begin
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h00a0_0113;
        rom[2] = 32'h0020_81b3;
        rom[3] = 32'h0000_0013;
        for (int i = 4; i < 32; i++)
            rom[i] = 32'h0000_0013 | (32'(i) << 20);

        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Sequential fetch of words 0 and 1
        tick(); check_ifid("seq0", 32'h0050_0093, 32'h0040_0000, 1'b1, 1'b0);
        tick(); check_ifid("seq1", 32'h00a0_0113, 32'h0040_0004, 1'b1, 1'b0);
        check("seq1.count", fetch_count, 32'd2);

        // Two-cycle stall holds everything
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_ifid("stall", 32'h00a0_0113, 32'h0040_0004, 1'b1, 1'b0);
            check("stall.addr",  imem_address, 32'h0040_0008);
            check("stall.count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick(); check_ifid("seq2", 32'h0020_81b3, 32'h0040_0008, 1'b1, 1'b0);
        tick(); check_ifid("seq3", 32'h0000_0013, 32'h0040_000C, 1'b1, 1'b0);
        check("seq3.count", fetch_count, 32'd4);

        // Redirect wins over a simultaneous stall; one bubble, then target
        redirect_valid = 1'b1; redirect_target = 32'h0040_0040; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        check("redir.addr", imem_address, 32'h0040_0040);
        check_ifid("redir.bubble", c_NOP, 32'd0, 1'b0, 1'b0);
        check("redir.count", fetch_count, 32'd4);
        tick(); check_ifid("redir.tgt", 32'h0100_0013, 32'h0040_0040, 1'b1, 1'b0);
        check("redir.tgt.count", fetch_count, 32'd5);

        // Flush bubbles IF/ID while the PC still advances
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_ifid("flush", c_NOP, 32'd0, 1'b0, 1'b0);
        check("flush.addr", imem_address, 32'h0040_0048);
        tick(); check_ifid("flush.next", 32'h0120_0013, 32'h0040_0048, 1'b1, 1'b0);
        check("flush.count", fetch_count, 32'd6);

        // Run off the end of the ROM
        redirect_valid = 1'b1; redirect_target = 32'h0040_007C;
        tick();
        redirect_valid = 1'b0;
        tick(); check_ifid("last", 32'h01F0_0013, 32'h0040_007C, 1'b1, 1'b0);
        tick(); check_ifid("oor", c_NOP, 32'h0040_0080, 1'b1, 1'b1);
        check("oor.halted", {31'd0, halted}, 32'd1);
        check("oor.addr",   imem_address, 32'h0040_0080);
        check("oor.count",  fetch_count, 32'd7);
        tick(); check_ifid("halt.bubble", c_NOP, 32'd0, 1'b0, 1'b0);
        check("halt.addr",   imem_address, 32'h0040_0080);
        check("halt.halted", {31'd0, halted}, 32'd1);

        // Redirect leaves HALT
        redirect_valid = 1'b1; redirect_target = c_BASE;
        tick();
        redirect_valid = 1'b0;
        check("resume.halted", {31'd0, halted}, 32'd0);
        check("resume.addr",   imem_address, c_BASE);
        tick(); check_ifid("resume", 32'h0050_0093, c_BASE, 1'b1, 1'b0);
        check("resume.count", fetch_count, 32'd8);

        // Misaligned redirect target faults one cycle later
        redirect_valid = 1'b1; redirect_target = 32'h0040_0006;
        tick();
        redirect_valid = 1'b0;
        check("mis.addr",   imem_address, 32'h0040_0006);
        check("mis.halted0", {31'd0, halted}, 32'd0);
        tick(); check_ifid("mis", c_NOP, 32'h0040_0006, 1'b1, 1'b1);
        check("mis.halted", {31'd0, halted}, 32'd1);
        check("mis.count",  fetch_count, 32'd8);

        // Below the text segment also faults
        redirect_valid = 1'b1; redirect_target = 32'h003F_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick(); check_ifid("low", c_NOP, 32'h003F_FFFC, 1'b1, 1'b1);
        check("low.halted", {31'd0, halted}, 32'd1);

        redirect_valid = 1'b1; redirect_target = c_BASE;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        check("pre.count", fetch_count, 32'd10);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check_reset_state("areset");
        @(posedge clk);
        #1 reset = 1'b0;
        tick(); check_ifid("post", 32'h0050_0093, c_BASE, 1'b1, 1'b0);
        check("post.count", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
